// File: rtl/rx_seek_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : rx_seek_pkg                                                 |
// | Purpose  : Constants and types shared by the RX window builder/seeker. |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package rx_seek_pkg;

  localparam int WINDOW_W = 67;
  localparam int BLOCK_W  = 66;
  localparam int HDR_W    = 2;
  localparam int POS_W    = 7;

  typedef logic [WINDOW_W-1:0] window_t;

endpackage : rx_seek_pkg
`default_nettype wire

// File: rtl/rx_window_builder_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : rx_window_builder_if                                       |
// | Purpose   : Word input and window output bundle for rx_window_builder. |
// |             bitslip_i exists only when RX_BITSLIP_EN is defined.       |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
interface rx_window_builder_if #(
  parameter int WORD_W = 32
) ();
  import rx_seek_pkg::*;

  logic [WORD_W-1:0] data_i;
  logic              data_dv;
`ifdef RX_BITSLIP_EN
  logic              bitslip_i;
`endif
  logic              buffer_dv;
  window_t           buffer;

`ifdef RX_BITSLIP_EN
  modport master (output data_i, data_dv, bitslip_i, input  buffer_dv, buffer);
  modport slave  (input  data_i, data_dv, bitslip_i, output buffer_dv, buffer);
`else
  modport master (output data_i, data_dv, input  buffer_dv, buffer);
  modport slave  (input  data_i, data_dv, output buffer_dv, buffer);
`endif

endinterface : rx_window_builder_if
`default_nettype wire

// File: rtl/rx_window_builder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : rx_window_builder                                           |
// | Purpose  : Packs RX words into 67-bit windows overlapping by one bit.   |
// |            Optional bit-slip support under macro RX_BITSLIP_EN.        |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module rx_window_builder
  import rx_seek_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  wire logic           clk_i,
  input  wire logic           rst_i,
  rx_window_builder_if.slave  bus
);

  // Only the low BLOCK_W bits survive a cycle; the upper WORD_W bits of the
  // shifted store are consumed by the window extraction in the same cycle.
  logic [BLOCK_W-1:0]        r_store;
  logic [POS_W-1:0]          r_count;
  logic                      r_buffer_dv;
  window_t                   r_buffer;

  logic [POS_W-1:0]          w_count_eff;
  logic [WORD_W+BLOCK_W-1:0] w_store_shift;
  logic [7:0]                w_n;
  logic                      w_emit;
  window_t                   w_window;
  logic [POS_W-1:0]          w_count_next;

`ifdef RX_BITSLIP_EN
  // Dropping the oldest bit is just forgetting it: shrink the valid count.
  assign w_count_eff = r_count - POS_W'(bus.bitslip_i && (r_count != '0));
`else
  assign w_count_eff = r_count;
`endif

  always_comb begin
    w_store_shift = {r_store, bus.data_i};
    w_n           = 8'(w_count_eff) + 8'(WORD_W);
    w_emit        = (w_n >= 8'(WINDOW_W));
    w_window      = WINDOW_W'(w_store_shift >> (w_n - 8'(WINDOW_W)));
    w_count_next  = w_emit ? POS_W'(w_n - 8'(BLOCK_W)) : POS_W'(w_n);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_store     <= '0;
      r_count     <= '0;
      r_buffer_dv <= 1'b0;
      r_buffer    <= '0;
    end else begin
      r_buffer_dv <= 1'b0;
      if (bus.data_dv) begin
        r_store <= w_store_shift[BLOCK_W-1:0];
        r_count <= w_count_next;
        if (w_emit) begin
          r_buffer_dv <= 1'b1;
          r_buffer    <= w_window;
        end
      end else begin
        r_count <= w_count_eff;
      end
    end
  end

  assign bus.buffer_dv = r_buffer_dv;
  assign bus.buffer    = r_buffer;

endmodule : rx_window_builder
`default_nettype wire

// File: tb/tb_rx_window_builder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_rx_window_builder                                        |
// | Purpose  : Scoreboard bench for rx_window_builder (RX_BITSLIP_EN opt.). |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_rx_window_builder;
  import rx_seek_pkg::*;

  localparam int WORD_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_window_builder_if #(.WORD_W(WORD_W)) bus ();

  rx_window_builder #(.WORD_W(WORD_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  bit          bitq[$];
  window_t     exp_q[$];
  logic        exp_dv   = 1'b0;
  window_t     exp_buf  = '0;
  bit          src_q[$];
  logic [63:0] blk_cnt  = '0;
  logic [63:0] exp_blk  = '0;
  int          hdr_off  = 0;
  bit          hdr_en   = 1'b0;
  bit          mon_en   = 1'b0;
  bit          rec_en   = 1'b0;
  int          n_win    = 0;
  window_t     obs_q[$];
  window_t     ref_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle and advance the bit-queue reference model.
  task automatic cycle(input logic r, input logic dv, input logic slip,
                       input logic [WORD_W-1:0] w);
    window_t win;
    rst         = r;
    bus.data_dv = dv;
    bus.data_i  = w;
`ifdef RX_BITSLIP_EN
    bus.bitslip_i = slip;
`endif
    @(posedge clk);
    exp_dv = 1'b0;
    if (r) begin
      bitq.delete();
      exp_q.delete();
      exp_buf = '0;
    end else begin
      if (slip && bitq.size() > 0) void'(bitq.pop_front());
      if (dv) begin
        for (int i = WORD_W-1; i >= 0; i--) bitq.push_back(w[i]);
        if (bitq.size() >= WINDOW_W) begin
          for (int j = 0; j < WINDOW_W; j++) win[WINDOW_W-1-j] = bitq[j];
          exp_q.push_back(win);
          exp_buf = win;
          exp_dv  = 1'b1;
          for (int j = 0; j < BLOCK_W; j++) void'(bitq.pop_front());
        end
      end
    end
    #1;
  endtask

  task automatic start_stream();
    src_q.delete();
    blk_cnt = '0;
    exp_blk = '0;
    hdr_off = 0;
  endtask

  task automatic next_word(output logic [WORD_W-1:0] w);
    logic [BLOCK_W-1:0] blk;
    while (src_q.size() < WORD_W) begin
      blk = {2'b01, blk_cnt};
      for (int i = BLOCK_W-1; i >= 0; i--) src_q.push_back(blk[i]);
      blk_cnt++;
    end
    for (int i = WORD_W-1; i >= 0; i--) w[i] = src_q.pop_front();
  endtask

  task automatic run_stream(input int nwords, input bit gaps);
    logic [WORD_W-1:0] w;
    for (int i = 0; i < nwords; i++) begin
      if (gaps) repeat ($urandom_range(0, 5)) cycle(1'b0, 1'b0, 1'b0, '0);
      next_word(w);
      cycle(1'b0, 1'b1, 1'b0, w);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("buffer_dv", bus.buffer_dv, exp_dv);
      check("buffer_hold", bus.buffer, exp_buf);
      check("count", dut.r_count, bitq.size());
      if (bus.buffer_dv === 1'b1) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("sb_window", bus.buffer, exp_q.pop_front());
        if (rec_en) begin
          n_win++;
          obs_q.push_back(bus.buffer);
        end
        if (hdr_en) begin
          check("header_pos", bus.buffer[66-hdr_off -: 2], 2'b01);
          if (hdr_off == 0) begin
            check("payload_seq", bus.buffer[64:1], exp_blk);
            exp_blk++;
          end
        end
      end
    end
  end

  initial begin
    logic [WORD_W-1:0] w;
    rst         = 1'b1;
    bus.data_dv = 1'b0;
    bus.data_i  = '0;
`ifdef RX_BITSLIP_EN
    bus.bitslip_i = 1'b0;
`endif

    // Reset held for 3 cycles while data_dv toggles.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, k[0], 1'b0, 32'hDEADBEEF);
      mon_en = 1'b1;
    end
    check("rst_dv", bus.buffer_dv, 1'b0);
    check("rst_buffer", bus.buffer, 67'h0);
    check("rst_count", dut.r_count, 0);

    // First window.
    cycle(1'b0, 1'b1, 1'b0, 32'hFFFFFFFF);
    cycle(1'b0, 1'b1, 1'b0, 32'h00000000);
    check("first_early", bus.buffer_dv, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'hAAAAAAAA);
    check("first_dv", bus.buffer_dv, 1'b1);
    check("first_window", bus.buffer, {32'hFFFFFFFF, 32'h00000000, 3'b101});
    check("first_count", dut.r_count, 30);

    // Reset at count 30 with coincident data_dv.
    cycle(1'b1, 1'b1, 1'b0, 32'hFFFFFFFF);
    check("midrst_count", dut.r_count, 0);
    check("midrst_buffer", bus.buffer, 67'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h12345678);
    cycle(1'b0, 1'b1, 1'b0, 32'h9ABCDEF0);
    cycle(1'b0, 1'b1, 1'b0, 32'hE0000000);
    check("midrst_dv", bus.buffer_dv, 1'b1);
    check("midrst_window", bus.buffer, {32'h12345678, 32'h9ABCDEF0, 3'b111});

    // Continuous block stream.
    cycle(1'b1, 1'b0, 1'b0, '0);
    start_stream();
    hdr_en = 1'b1;
    rec_en = 1'b1;
    n_win  = 0;
    obs_q.delete();
    run_stream(66, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check("win_count_66", n_win, 31);
    run_stream(66, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check("win_count_132", n_win, 63);
    rec_en = 1'b0;
    ref_q  = obs_q;
    obs_q.delete();

    // Same stream with random gaps.
    cycle(1'b1, 1'b0, 1'b0, '0);
    start_stream();
    rec_en = 1'b1;
    run_stream(132, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, '0);
    rec_en = 1'b0;
    check("gap_win_count", obs_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < obs_q.size(); i++)
      check("gap_window", obs_q[i], ref_q[i]);

`ifdef RX_BITSLIP_EN
    cycle(1'b1, 1'b0, 1'b0, '0);
    start_stream();
    cycle(1'b0, 1'b0, 1'b1, '0);
    check("slip_at_zero", dut.r_count, 0);
    run_stream(20, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, '0);
    hdr_off = 65;
    run_stream(20, 1'b0);
    next_word(w);
    cycle(1'b0, 1'b1, 1'b1, w);
    hdr_off = 64;
    run_stream(20, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_rx_window_builder
`default_nettype wire
